// File: rtl/sfx_sequencer_if.sv
// Trigger/mute inputs and playback status outputs of the sound-effect sequencer.
// The master side drives triggers and mute; the slave side is the sequencer.
interface sfx_sequencer_if #(
    parameter int NUM_SFX = 4,
    parameter int NOTES   = 4
);
    localparam int SFX_W  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
    localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;

    logic [NUM_SFX-1:0] trigger;
    logic               mute;
    logic               sound_out;
    logic               busy;
    logic [SFX_W-1:0]   active_sfx;
    logic [NOTE_W-1:0]  note_idx;

    modport master (
        output trigger, mute,
        input  sound_out, busy, active_sfx, note_idx
    );

    modport slave (
        input  trigger, mute,
        output sound_out, busy, active_sfx, note_idx
    );
endinterface

// File: rtl/sfx_sequencer.sv
// Square-wave sound-effect player: rising trigger edges start, retrigger or pre-empt
// fixed-length note melodies from a parameter table; one registered speaker bit out.
//
// state | meaning
// IDLE  | silent, waiting for a trigger rising edge
// PLAY  | stepping through the notes of effect active_sfx
module sfx_sequencer #(
    parameter int NUM_SFX    = 4,
    parameter int NOTES      = 4,
    parameter int DIV_W      = 17,
    parameter int DUR_W      = 24,
    parameter int NOTE_TICKS = 3_125_000,
    parameter logic [NUM_SFX*NOTES*DIV_W-1:0] HALF_PERIODS = '0
) (
    input  logic           clk,
    input  logic           reset,
    sfx_sequencer_if.slave bus
);
    localparam int SFX_W  = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;
    localparam int NOTE_W = (NOTES > 1) ? $clog2(NOTES) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t             state;
    logic [NUM_SFX-1:0] prev_trig;
    logic [NUM_SFX-1:0] rise;
    logic [SFX_W-1:0]   winner;
    logic [SFX_W-1:0]   active_q;
    logic [NOTE_W-1:0]  note_q;
    logic [DUR_W-1:0]   dur;
    logic [DIV_W-1:0]   phase;
    logic               tone;
    logic               tone_nxt;
    logic               sound_q;
    logic               start;
    logic               note_end;
    logic               last_note;
    logic               phase_wrap;
    logic [DIV_W-1:0]   h_cur;
    logic [DIV_W-1:0]   h_nxt;
    logic [DIV_W-1:0]   h_win;

    function automatic logic [DIV_W-1:0] half_of(input logic [SFX_W-1:0] s,
                                                input logic [NOTE_W-1:0] k);
        int unsigned base;
        base = (int'(s) * NOTES + int'(k)) * DIV_W;
        return HALF_PERIODS[base +: DIV_W];
    endfunction

    assign rise = bus.trigger & ~prev_trig;

    // Scan downwards so the lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_SFX - 1; i >= 0; i--) begin
            if (rise[i]) winner = SFX_W'(i);
        end
    end

    assign start      = (|rise) && (state == S_IDLE || winner <= active_q);
    assign note_end   = (dur == DUR_W'(NOTE_TICKS - 1));
    assign last_note  = (note_q == NOTE_W'(NOTES - 1));
    assign h_cur      = half_of(active_q, note_q);
    assign h_nxt      = half_of(active_q, last_note ? note_q : note_q + NOTE_W'(1));
    assign h_win      = half_of(winner, '0);
    assign phase_wrap = (h_cur != '0) && (phase == h_cur - DIV_W'(1));

    // Tone is computed ahead so sound_out follows a start with one cycle latency.
    always_comb begin
        tone_nxt = 1'b0;
        if (start) begin
            tone_nxt = (h_win != '0);
        end else if (state == S_PLAY) begin
            if (note_end)
                tone_nxt = last_note ? 1'b0 : (h_nxt != '0);
            else if (h_cur == '0)
                tone_nxt = 1'b0;
            else
                tone_nxt = phase_wrap ? ~tone : tone;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prev_trig <= '0;
            active_q  <= '0;
            note_q    <= '0;
            dur       <= '0;
            phase     <= '0;
            tone      <= 1'b0;
            sound_q   <= 1'b0;
        end else begin
            prev_trig <= bus.trigger;
            tone      <= tone_nxt;
            sound_q   <= tone_nxt & ~bus.mute;
            if (start) begin
                state    <= S_PLAY;
                active_q <= winner;
                note_q   <= '0;
                dur      <= '0;
                phase    <= '0;
            end else if (state == S_PLAY) begin
                if (note_end) begin
                    dur   <= '0;
                    phase <= '0;
                    if (last_note)
                        state <= S_IDLE;
                    else
                        note_q <= note_q + NOTE_W'(1);
                end else begin
                    dur <= dur + DUR_W'(1);
                    if (h_cur != '0)
                        phase <= phase_wrap ? '0 : phase + DIV_W'(1);
                end
            end
        end
    end

    assign bus.sound_out  = sound_q;
    assign bus.busy       = (state == S_PLAY);
    assign bus.active_sfx = active_q;
    assign bus.note_idx   = note_q;
endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed and random stimulus for sfx_sequencer, checked each cycle against an
// elapsed-time model of melody playback.
module tb_sfx_sequencer;
    localparam int NUM_SFX = 2;
    localparam int NOTES   = 3;
    localparam int NT      = 20;
    localparam int TAB [0:1][0:2] = '{'{4, 0, 2}, '{3, 3, 5}};

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference model: an effect is a start time plus elapsed cycles.
    logic [1:0] m_prev = 2'b00;
    bit         m_play = 0;
    int         m_sfx  = 0;
    int         m_e    = 0;

    always #5 clk = ~clk;

    sfx_sequencer_if #(.NUM_SFX(NUM_SFX), .NOTES(NOTES)) bus ();

    sfx_sequencer #(
        .NUM_SFX     (NUM_SFX),
        .NOTES       (NOTES),
        .DIV_W       (8),
        .DUR_W       (24),
        .NOTE_TICKS  (NT),
        .HALF_PERIODS(48'h05_03_03_02_00_04)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic model_step(input logic [1:0] trg, input logic rst);
        logic [1:0] r;
        int         w;
        if (rst) begin
            m_prev = 2'b00; m_play = 0; m_sfx = 0; m_e = 0;
            return;
        end
        r = trg & ~m_prev;
        m_prev = trg;
        w = r[0] ? 0 : 1;
        if (r != 2'b00 && (!m_play || w <= m_sfx)) begin
            m_play = 1; m_sfx = w; m_e = 0;
        end else if (m_play) begin
            m_e++;
            if (m_e >= NOTES * NT) m_play = 0;
        end
    endtask

    task automatic check(input logic mt);
        int   nk, off, h;
        logic e_snd;
        nk    = (m_e >= NOTES * NT) ? NOTES - 1 : m_e / NT;
        off   = m_e % NT;
        h     = TAB[m_sfx][nk];
        e_snd = m_play && !mt && h != 0 && ((off / h) % 2 == 0);
        total++;
        assert (bus.busy === m_play) else begin
            bad++; $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, bus.busy, m_play);
        end
        total++;
        assert (bus.sound_out === e_snd) else begin
            bad++; $error("FAIL sound_out cyc=%0d observed=%b expected=%b", cyc, bus.sound_out, e_snd);
        end
        total++;
        assert (int'(bus.active_sfx) === m_sfx) else begin
            bad++; $error("FAIL active_sfx cyc=%0d observed=%0d expected=%0d", cyc, bus.active_sfx, m_sfx);
        end
        total++;
        assert (int'(bus.note_idx) === nk) else begin
            bad++; $error("FAIL note_idx cyc=%0d observed=%0d expected=%0d", cyc, bus.note_idx, nk);
        end
    endtask

    task automatic cycle(input logic [1:0] trg, input logic mt, input logic rst);
        bus.trigger = trg;
        bus.mute    = mt;
        reset       = rst;
        @(posedge clk);
        cyc++;
        model_step(trg, rst);
        @(negedge clk);
        check(mt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [1:0] trg;
        logic       mt;
        logic       rst;
        bus.trigger = 2'b00;
        bus.mute    = 1'b0;
        reset       = 1'b1;

        // Reset with both triggers held; sfx0 wins on release, no replay.
        for (int i = 0; i < 5; i++) cycle(2'b11, 1'b0, 1'b1);
        for (int i = 0; i < 70; i++) cycle(2'b11, 1'b0, 1'b0);
        idle(5);

        // Single pulse on sfx1.
        cycle(2'b10, 1'b0, 1'b0);
        idle(65);

        // sfx0 held for 200 cycles.
        for (int i = 0; i < 200; i++) cycle(2'b01, 1'b0, 1'b0);
        idle(5);

        // Pre-emption by sfx0, then a dropped sfx1 edge.
        cycle(2'b10, 1'b0, 1'b0);
        idle(9);
        cycle(2'b01, 1'b0, 1'b0);
        idle(4);
        cycle(2'b10, 1'b0, 1'b0);
        idle(65);

        // Retrigger of sfx1 on the final PLAY cycle.
        cycle(2'b10, 1'b0, 1'b0);
        idle(59);
        cycle(2'b10, 1'b0, 1'b0);
        idle(70);

        // Mute mid-note, then reset mid-effect.
        cycle(2'b10, 1'b0, 1'b0);
        idle(10);
        for (int i = 0; i < 15; i++) cycle(2'b00, 1'b1, 1'b0);
        idle(40);
        cycle(2'b01, 1'b0, 1'b0);
        idle(25);
        cycle(2'b00, 1'b0, 1'b1);
        idle(10);

        // Random triggers, mute and occasional reset.
        trg = 2'b00;
        mt  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 15) == 0) trg[b] = ~trg[b];
            if ($urandom_range(0, 30) == 0) mt = ~mt;
            rst = ($urandom_range(0, 399) == 0);
            cycle(trg, mt, rst);
        end
        idle(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
